// File: rtl/raster_pkg.sv
// Shared types and screen constants for the triangle raster front end.
// Coordinates are plain unsigned W-bit values.
package raster_pkg;

  localparam int W     = 12;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int CW    = 24;

  typedef logic [W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BBOX = 3'd1,
    ST_SCAN = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/tri_scan_if.sv
// Bundle between tri_scan and its neighbours: triangle input, tester probe
// link, covered-pixel stream and status.
interface tri_scan_if #(
    parameter int CW = raster_pkg::CW
);
    import raster_pkg::*;

    // Both streams are valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; payload is stable while valid waits.
    logic          tri_valid;
    logic          tri_ready;
    coord_t        ax, ay, bx, by, cx, cy;

    coord_t        v_ax, v_ay, v_bx, v_by, v_cx, v_cy;
    coord_t        probe_x, probe_y;
    logic          probe_in;

    logic          pix_valid;
    logic          pix_ready;
    coord_t        pix_x, pix_y;

    logic          busy;
    logic          done;
    logic [CW-1:0] pix_count;
    logic [2:0]    dbgState;

    modport slave (
        input  tri_valid, ax, ay, bx, by, cx, cy, probe_in, pix_ready,
        output tri_ready, v_ax, v_ay, v_bx, v_by, v_cx, v_cy,
               probe_x, probe_y, pix_valid, pix_x, pix_y,
               busy, done, pix_count, dbgState
    );

    modport master (
        output tri_valid, ax, ay, bx, by, cx, cy, probe_in, pix_ready,
        input  tri_ready, v_ax, v_ay, v_bx, v_by, v_cx, v_cy,
               probe_x, probe_y, pix_valid, pix_x, pix_y,
               busy, done, pix_count, dbgState
    );

endinterface

// File: rtl/bbox_calc.sv
// Min/max of three coordinates along one axis, with the max clamped to the
// last on-screen value and a flag when the whole span lies off screen.
module bbox_calc
    import raster_pkg::*;
#(
    parameter int LIMIT = raster_pkg::SCR_W
) (
    input  coord_t a,
    input  coord_t b,
    input  coord_t c,
    output coord_t lo,
    output coord_t hi,
    output logic   off
);

    localparam coord_t EDGE = coord_t'(LIMIT - 1);

    coord_t maxV;

    always_comb begin
        lo = a;
        if (b < lo) lo = b;
        if (c < lo) lo = c;
        maxV = a;
        if (b > maxV) maxV = b;
        if (c > maxV) maxV = c;
        hi  = (maxV > EDGE) ? EDGE : maxV;
        off = (lo > EDGE);
    end

endmodule

// File: rtl/tri_scan.sv
// Bounding-box scan controller: accepts a triangle, walks its clamped box in
// raster order through the external tester and streams the covered pixels.
module tri_scan #(
    parameter int SCR_W = raster_pkg::SCR_W,
    parameter int SCR_H = raster_pkg::SCR_H,
    parameter int CW    = raster_pkg::CW
) (
    input logic       clk,
    input logic       rst,
    tri_scan_if.slave bus
);
    import raster_pkg::*;

    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] BBOX = ST_BBOX;
    localparam logic [2:0] SCAN = ST_SCAN;
    localparam logic [2:0] EMIT = ST_EMIT;
    localparam logic [2:0] DONE = ST_DONE;

    logic [2:0]    state;
    coord_t        vAx, vAy, vBx, vBy, vCx, vCy;
    coord_t        xMin, xMax, yMin, yMax;
    coord_t        probeX, probeY;
    coord_t        pixX, pixY;
    logic [CW-1:0] pixCount;

    coord_t        bxLo, bxHi, byLo, byHi;
    logic          bxOff, byOff;

    bbox_calc #(.LIMIT(SCR_W)) u_bboxX (
        .a(vAx), .b(vBx), .c(vCx), .lo(bxLo), .hi(bxHi), .off(bxOff)
    );

    bbox_calc #(.LIMIT(SCR_H)) u_bboxY (
        .a(vAy), .b(vBy), .c(vCy), .lo(byLo), .hi(byHi), .off(byOff)
    );

    // Raster step shared by SCAN (miss) and EMIT (after handshake).
    logic   lastCol, lastPt;
    coord_t nextX, nextY;

    always_comb begin
        lastCol = (probeX >= xMax);
        lastPt  = lastCol && (probeY >= yMax);
        nextX   = lastCol ? xMin : probeX + coord_t'(1);
        nextY   = lastCol ? probeY + coord_t'(1) : probeY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            vAx      <= '0;
            vAy      <= '0;
            vBx      <= '0;
            vBy      <= '0;
            vCx      <= '0;
            vCy      <= '0;
            xMin     <= '0;
            xMax     <= '0;
            yMin     <= '0;
            yMax     <= '0;
            probeX   <= '0;
            probeY   <= '0;
            pixX     <= '0;
            pixY     <= '0;
            pixCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.tri_valid) begin
                        vAx      <= bus.ax;
                        vAy      <= bus.ay;
                        vBx      <= bus.bx;
                        vBy      <= bus.by;
                        vCx      <= bus.cx;
                        vCy      <= bus.cy;
                        pixCount <= '0;
                        state    <= BBOX;
                    end
                end
                BBOX: begin
                    xMin <= bxLo;
                    xMax <= bxHi;
                    yMin <= byLo;
                    yMax <= byHi;
                    if (bxOff || byOff) begin
                        state <= DONE;
                    end else begin
                        probeX <= bxLo;
                        probeY <= byLo;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.probe_in) begin
                        pixX  <= probeX;
                        pixY  <= probeY;
                        state <= EMIT;
                    end else if (lastPt) begin
                        state <= DONE;
                    end else begin
                        probeX <= nextX;
                        probeY <= nextY;
                    end
                end
                EMIT: begin
                    if (bus.pix_ready) begin
                        if (pixCount != '1) pixCount <= pixCount + 1'b1;
                        if (lastPt) begin
                            state <= DONE;
                        end else begin
                            probeX <= nextX;
                            probeY <= nextY;
                            state  <= SCAN;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tri_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.pix_valid = (state == EMIT);
    assign bus.pix_x     = pixX;
    assign bus.pix_y     = pixY;
    assign bus.probe_x   = probeX;
    assign bus.probe_y   = probeY;
    assign bus.pix_count = pixCount;
    assign bus.dbgState  = state;
    assign bus.v_ax      = vAx;
    assign bus.v_ay      = vAy;
    assign bus.v_bx      = vBx;
    assign bus.v_by      = vBy;
    assign bus.v_cx      = vCx;
    assign bus.v_cy      = vCy;

endmodule

// File: tb/tb_tri_scan.sv
// Bench for tri_scan: a behavioural tester drives probe_in, and the expected
// probe/pixel sequences come from a raster walk over the clamped box.
module tb_tri_scan;
    import raster_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tri_scan_if bus ();
    tri_scan dut (.clk(clk), .rst(rst), .bus(bus));

    int errCount   = 0;
    int checkCount = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Tester model: inclusive edge-function test, either winding accepted.
    function automatic bit inTri(int ax, int ay, int bx, int by, int cx, int cy, int px, int py);
        int e0, e1, e2;
        e0 = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
        e1 = (cx - bx) * (py - by) - (cy - by) * (px - bx);
        e2 = (ax - cx) * (py - cy) - (ay - cy) * (px - cx);
        return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
    endfunction

    bit forceOn  = 1'b0;
    bit forceVal = 1'b0;
    int readyMode = 0;
    int stallLeft = 0;

    assign bus.probe_in = forceOn ? forceVal
                        : inTri(int'(bus.v_ax), int'(bus.v_ay), int'(bus.v_bx), int'(bus.v_by),
                                int'(bus.v_cx), int'(bus.v_cy), int'(bus.probe_x), int'(bus.probe_y));

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] probeQ[$];
    logic [2*W-1:0] expQ[$];
    int nProbeQ[$], nPixQ[$], latQ[$];
    int probesSeen = 0, pixSeen = 0, curEmit = 0, firstEmitLen = 0;
    int cyc = 0, acceptCyc = 0, doneCyc = 0;
    bit monOn = 1'b0;
    bit stallPrev = 1'b0;
    logic [2*W-1:0] prevPix;

    function automatic logic [2*W-1:0] packXY(int x, int y);
        return {coord_t'(y), coord_t'(x)};
    endfunction

    task automatic planTri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input bit fixedLat);
        int xLo, xHi, yLo, yHi, nP, nC;
        bit cov;
        xLo = (ax < bx) ? ax : bx;  xLo = (cx < xLo) ? cx : xLo;
        xHi = (ax > bx) ? ax : bx;  xHi = (cx > xHi) ? cx : xHi;
        yLo = (ay < by) ? ay : by;  yLo = (cy < yLo) ? cy : yLo;
        yHi = (ay > by) ? ay : by;  yHi = (cy > yHi) ? cy : yHi;
        if (xHi > SCR_W - 1) xHi = SCR_W - 1;
        if (yHi > SCR_H - 1) yHi = SCR_H - 1;
        nP = 0;
        nC = 0;
        if (xLo <= SCR_W - 1 && yLo <= SCR_H - 1) begin
            for (int y = yLo; y <= yHi; y++) begin
                for (int x = xLo; x <= xHi; x++) begin
                    probeQ.push_back(packXY(x, y));
                    nP++;
                    cov = forceOn ? forceVal : inTri(ax, ay, bx, by, cx, cy, x, y);
                    if (cov) begin
                        expQ.push_back(packXY(x, y));
                        nC++;
                    end
                end
            end
        end
        nProbeQ.push_back(nP);
        nPixQ.push_back(nC);
        latQ.push_back(fixedLat ? 2 + nP + nC : -1);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (monOn && !rst) begin
            if (bus.tri_valid && bus.tri_ready) acceptCyc = cyc;
            if (bus.busy && bus.tri_valid) checkEq("tri_ready_busy", bus.tri_ready, 0);
            if (bus.dbgState == 3'(ST_SCAN)) begin
                probesSeen++;
                if (probeQ.size() == 0) checkEq("probe_extra", 1, 0);
                else checkEq("probe_xy", {bus.probe_y, bus.probe_x}, probeQ.pop_front());
            end
            if (bus.pix_valid) begin
                curEmit++;
                checkEq("probe_hold", {bus.probe_y, bus.probe_x}, {bus.pix_y, bus.pix_x});
                if (stallPrev) checkEq("pix_stable", {bus.pix_y, bus.pix_x}, prevPix);
                if (bus.pix_ready) begin
                    if (pixSeen == 0) firstEmitLen = curEmit;
                    curEmit = 0;
                    pixSeen++;
                    if (expQ.size() == 0) checkEq("pix_extra", 1, 0);
                    else checkEq("pix_xy", {bus.pix_y, bus.pix_x}, expQ.pop_front());
                end
            end else if (stallPrev) begin
                checkEq("pix_valid_hold", bus.pix_valid, 1);
            end
            stallPrev = bus.pix_valid && !bus.pix_ready;
            prevPix   = {bus.pix_y, bus.pix_x};
            if (bus.done) begin
                doneCyc = cyc;
                if (nProbeQ.size() == 0) checkEq("done_extra", 1, 0);
                else begin
                    int lat;
                    checkEq("n_probes", probesSeen, nProbeQ.pop_front());
                    checkEq("n_pixels", pixSeen, nPixQ.pop_front());
                    checkEq("pix_count", bus.pix_count, pixSeen);
                    lat = latQ.pop_front();
                    if (lat >= 0) checkEq("done_cycle", cyc - acceptCyc, lat);
                end
                probesSeen = 0;
                pixSeen    = 0;
                curEmit    = 0;
            end
        end
    end

    // ---------------- drivers ----------------
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0: bus.pix_ready = 1'b1;
            1: bus.pix_ready = ($urandom_range(0, 2) != 0);
            default: begin
                if (bus.pix_valid && stallLeft > 0) begin
                    bus.pix_ready = 1'b0;
                    stallLeft--;
                end else begin
                    bus.pix_ready = 1'b1;
                end
            end
        endcase
    end

    task automatic setVerts(input int ax, input int ay, input int bx, input int by, input int cx, input int cy);
        bus.ax = coord_t'(ax); bus.ay = coord_t'(ay);
        bus.bx = coord_t'(bx); bus.by = coord_t'(by);
        bus.cx = coord_t'(cx); bus.cy = coord_t'(cy);
    endtask

    task automatic sendTri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input bit hold);
        bit ok = 1'b0;
        @(posedge clk); #1;
        setVerts(ax, ay, bx, by, cx, cy);
        bus.tri_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.tri_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) checkEq("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (!hold) bus.tri_valid = 1'b0;
    endtask

    task automatic waitDone();
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (bus.done) begin ok = 1'b1; break; end
        end
        if (!ok) checkEq("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic runTri(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy, input bit fixedLat);
        planTri(ax, ay, bx, by, cx, cy, fixedLat);
        sendTri(ax, ay, bx, by, cx, cy, 1'b0);
        waitDone();
    endtask

    task automatic checkIdle(input string tag);
        checkEq({tag, "_tri_ready"}, bus.tri_ready, 1);
        checkEq({tag, "_busy"}, bus.busy, 0);
        checkEq({tag, "_done"}, bus.done, 0);
        checkEq({tag, "_pix_valid"}, bus.pix_valid, 0);
        checkEq({tag, "_pix_count"}, bus.pix_count, 0);
        checkEq({tag, "_probe"}, {bus.probe_y, bus.probe_x}, 0);
        checkEq({tag, "_pix"}, {bus.pix_y, bus.pix_x}, 0);
        checkEq({tag, "_verts"}, {bus.v_ax, bus.v_ay, bus.v_bx}, 0);
        checkEq({tag, "_verts2"}, {bus.v_by, bus.v_cx, bus.v_cy}, 0);
        checkEq({tag, "_state"}, bus.dbgState, 3'(ST_IDLE));
    endtask

    task automatic clearBoard();
        probeQ.delete(); expQ.delete();
        nProbeQ.delete(); nPixQ.delete(); latQ.delete();
        probesSeen = 0; pixSeen = 0; curEmit = 0; stallPrev = 1'b0;
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst = 1'b1;
        bus.tri_valid = 1'b0;
        bus.pix_ready = 1'b1;
        setVerts(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkIdle("reset");
        monOn = 1'b1;

        // single pixel, tester model says inside
        forceOn = 1'b0; readyMode = 0;
        runTri(5, 5, 5, 5, 5, 5, 1'b1);

        // nothing covered
        forceOn = 1'b1; forceVal = 1'b0;
        runTri(0, 0, 3, 0, 0, 2, 1'b1);

        // everything covered, first pixel stalled five cycles
        forceVal = 1'b1; readyMode = 2; stallLeft = 5;
        runTri(0, 0, 3, 0, 0, 2, 1'b0);
        checkEq("first_emit_len", firstEmitLen, 6);
        readyMode = 0;

        // clamp and off-screen boxes
        forceVal = 1'b0;
        runTri(630, 10, 4000, 12, 635, 14, 1'b1);
        runTri(640, 5, 700, 6, 650, 7, 1'b1);
        runTri(5, 480, 6, 500, 7, 490, 1'b1);

        // reset in the middle of a scan
        monOn = 1'b0;
        sendTri(0, 0, 3, 0, 0, 2, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkEq("pre_reset_scan", bus.dbgState, 3'(ST_SCAN));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkIdle("midrst");
        clearBoard();
        monOn = 1'b1;
        forceOn = 1'b0;
        runTri(1, 1, 6, 2, 2, 5, 1'b1);

        // second triangle offered while busy
        planTri(2, 2, 8, 3, 4, 7, 1'b1);
        planTri(1, 1, 6, 1, 1, 5, 1'b1);
        sendTri(2, 2, 8, 3, 4, 7, 1'b1);
        setVerts(1, 1, 6, 1, 1, 5);
        repeat (3) @(negedge clk);
        checkEq("va_held", {bus.v_ax, bus.v_ay}, {12'd2, 12'd2});
        waitDone();
        @(negedge clk);
        checkEq("b_accept_ready", bus.tri_ready, 1);
        checkEq("b_accept_cycle", cyc - doneCyc, 1);
        @(posedge clk); #1 bus.tri_valid = 1'b0;
        waitDone();

        // randomized triangles and backpressure
        readyMode = 1;
        for (int t = 0; t < 16; t++) begin
            int baseX, baseY;
            baseX = (t % 4 == 0) ? 628 : int'($urandom_range(0, 20));
            baseY = (t % 5 == 0) ? 470 : int'($urandom_range(0, 20));
            forceOn = (t % 6 == 5);
            forceVal = 1'($urandom_range(0, 1));
            runTri(baseX + int'($urandom_range(0, 14)), baseY + int'($urandom_range(0, 14)),
                   baseX + int'($urandom_range(0, 14)), baseY + int'($urandom_range(0, 14)),
                   baseX + int'($urandom_range(0, 14)), baseY + int'($urandom_range(0, 14)), 1'b0);
        end

        checkEq("left_probes", probeQ.size(), 0);
        checkEq("left_pixels", expQ.size(), 0);
        checkEq("left_tris", nProbeQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
